// File: rtl/state_packet_tx.sv
// Captures a snapshot of the local game state and sends it as a 13-byte
// framed packet (sync, 11 payload bytes, checksum) over an 8N1 UART line.
module state_packet_tx #(
  parameter int unsigned CLKS_PER_BIT = 218,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [1:0]  player_id,
  input  logic [2:0]  game_state,
  input  logic [7:0]  time_left,
  input  logic [9:0]  point_total,
  input  logic [3:0]  orders,
  input  logic [3:0]  player_state,
  input  logic [23:0] team_name,
  input  logic [1:0]  player_direction,
  input  logic [8:0]  player_loc_x,
  input  logic [8:0]  player_loc_y,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] packets_sent
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BYTE = 4'd12;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, FINISH} state_t;

  state_t        state, state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic          pending;
  logic [15:0]   sent_count;
  logic          launch;
  logic          sending;
  logic          bit_done;

  logic [1:0]  snap_player_id;
  logic [2:0]  snap_game_state;
  logic [7:0]  snap_time_left;
  logic [9:0]  snap_point_total;
  logic [3:0]  snap_orders;
  logic [3:0]  snap_player_state;
  logic [23:0] snap_team_name;
  logic [1:0]  snap_direction;
  logic [8:0]  snap_loc_x;
  logic [8:0]  snap_loc_y;

  logic [7:0] pkt [16];
  logic [7:0] checksum;
  logic [7:0] cur_byte;

  // Packet bytes are a pure function of the snapshot, so mid-packet input
  // changes can never reach the line.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) pkt[i] = '0;
    pkt[0]  = SYNC_BYTE;
    pkt[1]  = {snap_player_id, 3'b000, snap_game_state};
    pkt[2]  = snap_time_left;
    pkt[3]  = {6'b0, snap_point_total[9:8]};
    pkt[4]  = snap_point_total[7:0];
    pkt[5]  = {snap_orders, snap_player_state};
    pkt[6]  = snap_team_name[23:16];
    pkt[7]  = snap_team_name[15:8];
    pkt[8]  = snap_team_name[7:0];
    pkt[9]  = {snap_direction, 4'b0, snap_loc_y[8], snap_loc_x[8]};
    pkt[10] = snap_loc_x[7:0];
    pkt[11] = snap_loc_y[7:0];
    checksum = '0;
    for (int unsigned i = 1; i < 12; i++) checksum = checksum + pkt[i];
    pkt[12] = checksum;
    cur_byte = pkt[byte_idx];
  end

  assign sending      = (state == START) || (state == DATA) || (state == STOP);
  assign bit_done     = (baud_cnt == BIT_LAST);
  assign packets_sent = sent_count;

  always_comb begin
    state_next = state;
    tx         = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (send) begin
          launch     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx   = 1'b0;
        busy = 1'b1;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        tx   = cur_byte[bit_idx];
        busy = 1'b1;
        if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        busy = 1'b1;
        if (bit_done) state_next = (byte_idx == LAST_BYTE) ? FINISH : START;
      end
      FINISH: begin
        // A queued request keeps busy high and relaunches without an idle gap.
        done = 1'b1;
        busy = pending;
        if (pending || send) begin
          launch     = 1'b1;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      baud_cnt          <= '0;
      bit_idx           <= '0;
      byte_idx          <= '0;
      pending           <= 1'b0;
      sent_count        <= '0;
      snap_player_id    <= '0;
      snap_game_state   <= '0;
      snap_time_left    <= '0;
      snap_point_total  <= '0;
      snap_orders       <= '0;
      snap_player_state <= '0;
      snap_team_name    <= '0;
      snap_direction    <= '0;
      snap_loc_x        <= '0;
      snap_loc_y        <= '0;
    end else begin
      state <= state_next;

      if (sending && !bit_done) baud_cnt <= baud_cnt + 1'b1;
      else                      baud_cnt <= '0;

      if (state == DATA && bit_done) bit_idx <= bit_idx + 1'b1;

      if (launch)                        byte_idx <= '0;
      else if (state == STOP && bit_done) byte_idx <= byte_idx + 1'b1;

      if (launch)               pending <= 1'b0;
      else if (sending && send) pending <= 1'b1;

      if (state == FINISH) sent_count <= sent_count + 16'd1;

      if (launch) begin
        snap_player_id    <= player_id;
        snap_game_state   <= game_state;
        snap_time_left    <= time_left;
        snap_point_total  <= point_total;
        snap_orders       <= orders;
        snap_player_state <= player_state;
        snap_team_name    <= team_name;
        snap_direction    <= player_direction;
        snap_loc_x        <= player_loc_x;
        snap_loc_y        <= player_loc_y;
      end
    end
  end

endmodule

// File: tb/tb_state_packet_tx.sv
// Randomized and directed bench for state_packet_tx: a packet-level model
// queues expected frames, and a UART monitor decodes the line against them.
module tb_state_packet_tx;

  localparam int unsigned CPB        = 4;
  localparam int unsigned PKT_CYCLES = 130 * CPB;

  logic        clock = 1'b0;
  logic        reset;
  logic        send;
  logic [1:0]  player_id;
  logic [2:0]  game_state;
  logic [7:0]  time_left;
  logic [9:0]  point_total;
  logic [3:0]  orders;
  logic [3:0]  player_state;
  logic [23:0] team_name;
  logic [1:0]  player_direction;
  logic [8:0]  player_loc_x;
  logic [8:0]  player_loc_y;
  logic        tx;
  logic        busy;
  logic        done;
  logic [15:0] packets_sent;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clock = ~clock;

  state_packet_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .send(send),
    .player_id(player_id), .game_state(game_state), .time_left(time_left),
    .point_total(point_total), .orders(orders), .player_state(player_state),
    .team_name(team_name), .player_direction(player_direction),
    .player_loc_x(player_loc_x), .player_loc_y(player_loc_y),
    .tx(tx), .busy(busy), .done(done), .packets_sent(packets_sent)
  );

  typedef struct {
    logic [12:0][7:0] bytes;
    int unsigned      start;
  } pkt_t;

  pkt_t exp_q[$];

  int unsigned cyc = 0;
  int unsigned left = 0;
  bit          in_done = 0;
  bit          pend = 0;
  bit          was_reset = 0;
  bit          force_req = 0;
  bit          exp_busy = 0;
  bit          exp_done = 0;
  logic [15:0] m_count = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [12:0][7:0] build_packet();
    logic [12:0][7:0] p;
    int unsigned sum = 0;
    p[0]  = 8'hA5;
    p[1]  = 8'(int'(player_id) * 64 + int'(game_state));
    p[2]  = time_left;
    p[3]  = 8'(int'(point_total) / 256);
    p[4]  = 8'(int'(point_total) % 256);
    p[5]  = 8'(int'(orders) * 16 + int'(player_state));
    p[6]  = 8'(int'(team_name) / 65536);
    p[7]  = 8'((int'(team_name) / 256) % 256);
    p[8]  = 8'(int'(team_name) % 256);
    p[9]  = 8'(int'(player_direction) * 64 + (int'(player_loc_y) / 256) * 2
               + int'(player_loc_x) / 256);
    p[10] = 8'(int'(player_loc_x) % 256);
    p[11] = 8'(int'(player_loc_y) % 256);
    for (int unsigned i = 1; i < 12; i++) sum += int'(p[i]);
    p[12] = 8'(sum % 256);
    return p;
  endfunction

  // Packet-level reference: a launch occupies PKT_CYCLES cycles, then one done cycle.
  always @(posedge clock) begin : model
    pkt_t p;
    cyc++;
    was_reset = 0;
    if (reset) begin
      left = 0; in_done = 0; pend = 0; m_count = '0;
      exp_q.delete();
      was_reset = 1;
    end else begin
      if (force_req) m_count = 16'hFFFF;
      if (left > 0) begin
        if (send) pend = 1;
        left--;
        in_done = (left == 0);
      end else begin
        if (in_done) m_count++;
        if (send || pend) begin
          p.bytes = build_packet();
          p.start = cyc;
          exp_q.push_back(p);
          left = PKT_CYCLES;
          pend = 0;
        end
        in_done = 0;
      end
    end
    exp_done = in_done;
    exp_busy = (left > 0) || (in_done && pend);
  end

  logic [12:0][7:0] last_rx;
  logic [7:0]       rx_byte;
  pkt_t             cur;
  bit               mon_active = 0;
  int unsigned      off = 0;
  int unsigned      last_start = 0;
  int unsigned      done_seen = 0;

  always @(posedge clock) begin : monitor
    int unsigned k;
    #1;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("packets_sent", 32'(packets_sent), 32'(m_count));
    if (left == 0) chk("tx_idle", 32'(tx), 32'd1);
    if (done) begin
      done_seen++;
      chk("done_latency", cyc - last_start, PKT_CYCLES);
    end
    if (was_reset) begin
      mon_active = 0;
    end else if (!mon_active && tx == 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: got start bit expected idle (cycle %0d)", cyc);
      end else begin
        cur = exp_q.pop_front();
        chk("start_cycle", cyc, cur.start);
        mon_active = 1;
        off = 0;
        last_start = cyc;
      end
    end
    if (mon_active) begin
      if (off % CPB == CPB / 2) begin
        k = off / CPB;
        if (k % 10 == 0) chk("start_bit", 32'(tx), 32'd0);
        else if (k % 10 <= 8) rx_byte[k % 10 - 1] = tx;
        else begin
          chk("stop_bit", 32'(tx), 32'd1);
          chk($sformatf("byte%0d", k / 10), 32'(rx_byte), 32'(cur.bytes[k / 10]));
          last_rx[k / 10] = rx_byte;
        end
      end
      off++;
      if (off == PKT_CYCLES) mon_active = 0;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_send();
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned base = done_seen;
    int unsigned n = 0;
    while (done_seen == base && n < limit) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (done_seen == base) begin
      errors++;
      $display("FAIL wait_done: got no done expected one within %0d cycles", limit);
    end
  endtask

  task automatic demo_fields();
    player_id = 2'd1; game_state = 3'd2; time_left = 8'd150; point_total = 10'd300;
    orders = 4'b0101; player_state = 4'd3; team_name = 24'h414243;
    player_direction = 2'd1; player_loc_x = 9'd304; player_loc_y = 9'd208;
  endtask

  task automatic random_fields();
    player_id = 2'($urandom); game_state = 3'($urandom); time_left = 8'($urandom);
    point_total = 10'($urandom); orders = 4'($urandom); player_state = 4'($urandom);
    team_name = 24'($urandom); player_direction = 2'($urandom);
    player_loc_x = 9'($urandom); player_loc_y = 9'($urandom);
  endtask

  logic [7:0]  golden [13];
  logic [15:0] base_count;

  initial begin
    golden = '{8'hA5, 8'h42, 8'h96, 8'h01, 8'h2C, 8'h53, 8'h41,
               8'h42, 8'h43, 8'h41, 8'h30, 8'hD0, 8'h5F};
    reset = 1'b1;
    send  = 1'b0;
    demo_fields();
    tick(3);
    reset = 1'b0;

    // Quiet line after reset
    tick(1000);
    chk("idle_done_count", done_seen, 32'd0);
    chk("idle_packets", 32'(packets_sent), 32'd0);
    chk("idle_tx", 32'(tx), 32'd1);

    // Single packet with known bytes
    pulse_send();
    wait_done(PKT_CYCLES + 20);
    for (int unsigned i = 0; i < 13; i++)
      chk($sformatf("golden%0d", i), 32'(last_rx[i]), 32'(golden[i]));
    tick(1);
    chk("single_count", 32'(packets_sent), 32'd1);

    // Inputs change while byte 5 is on the line
    pulse_send();
    tick(5 * 10 * CPB);
    time_left = 8'd0;
    wait_done(PKT_CYCLES + 20);
    chk("hold_b2", 32'(last_rx[2]), 32'h96);
    chk("hold_sum", 32'(last_rx[12]), 32'h5F);
    tick(1);
    demo_fields();

    // Repeated requests during a packet collapse into one follow-on packet
    base_count = packets_sent;
    pulse_send();
    tick(50);  pulse_send();
    tick(100); pulse_send();
    tick(100); pulse_send();
    wait_done(PKT_CYCLES + 20);
    wait_done(PKT_CYCLES + 20);
    tick(3);
    chk("b2b_busy", 32'(busy), 32'd0);
    chk("b2b_count", 32'(packets_sent), 32'(base_count + 16'd2));

    // Reset while B4 data bits are in flight
    pulse_send();
    tick(4 * 10 * CPB + 10);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(packets_sent), 32'd0);
    random_fields();
    pulse_send();
    wait_done(PKT_CYCLES + 20);
    chk("rst_sync", 32'(last_rx[0]), 32'hA5);
    tick(1);
    chk("rst_new_count", 32'(packets_sent), 32'd1);

    // Counter wrap
    tick(5);
    force dut.sent_count = 16'hFFFF;
    force_req = 1;
    @(negedge clock);
    release dut.sent_count;
    force_req = 0;
    pulse_send();
    wait_done(PKT_CYCLES + 20);
    tick(2);
    chk("wrap_count", 32'(packets_sent), 32'd0);

    // Random traffic, field churn and occasional reset
    for (int unsigned i = 0; i < 4000; i++) begin
      send = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 5) random_fields();
      reset = ($urandom_range(0, 2999) == 0);
      @(negedge clock);
    end
    send  = 1'b0;
    reset = 1'b0;
    for (int unsigned n = 0; n < 2 * PKT_CYCLES + 20 && (busy || done); n++)
      @(negedge clock);
    tick(5);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_packet_tx.md
Name: state_packet_tx

Overview:
- Serializes a snapshot of the local game state into a fixed 13-byte framed packet and transmits it as an 8N1 UART stream toward the score server and peer boards.
- It is the transmit end of the state link. The game logic block produces the fields; this block captures them and sends them out.
- It sits beside the game logic. Its `send` input is typically driven by `frame_update`.

Parameters:
- CLKS_PER_BIT, 218, clock cycles per UART bit (25.175 MHz / 115200 baud). Minimum legal value is 2.
- SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- send  input  1  request to transmit one packet (level-sampled each cycle)
- player_id  input  2  local player ID
- game_state  input  3  current game state
- time_left  input  8  seconds remaining
- point_total  input  10  score
- orders  input  4  active order bits
- player_state  input  4  local player state
- team_name  input  3x8  ASCII letters; index 2 is the first letter
- player_direction  input  2  facing direction
- player_loc_x  input  9  pixel x
- player_loc_y  input  9  pixel y
- tx  output  1  UART line, idle high
- busy  output  1  packet in flight
- done  output  1  one-cycle pulse when a packet's final stop bit ends
- packets_sent  output  16  count of completed packets, wraps at 16'hFFFF to 0

Behaviour:
- Reset values:
  - tx=1, busy=0, done=0, packets_sent=0.
  - pending=0; FSM in IDLE; all snapshot registers 0.
- Clocking: reset is synchronous, active-high, on clock `clock`.
- Packet byte order, 13 bytes:
  - B0 = SYNC_BYTE
  - B1 = {player_id, 3'b000, game_state}
  - B2 = time_left
  - B3 = {6'b0, point_total[9:8]}
  - B4 = point_total[7:0]
  - B5 = {orders, player_state}
  - B6 = team_name[2], B7 = team_name[1], B8 = team_name[0]
  - B9 = {player_direction, 4'b0, player_loc_y[8], player_loc_x[8]}
  - B10 = player_loc_x[7:0]
  - B11 = player_loc_y[7:0]
  - B12 = checksum = (B1 + ... + B11) mod 256; B0 is excluded.
- Byte framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit holds exactly CLKS_PER_BIT cycles. There is no gap between bytes.
- FSM states: IDLE -> START -> DATA (bit index 0..7) -> STOP -> next byte START, or FINISH after B12.
- Packet start:
  - If send=1 in IDLE at cycle t, all inputs are registered into the snapshot at edge t.
  - tx goes low (start bit of B0) and busy goes high from cycle t+1.
  - The checksum is accumulated from the snapshot while bytes are sent, or precomputed; either way B12 must match the formula above.
- Packet end:
  - Total packet length is 130*CLKS_PER_BIT cycles.
  - On the cycle after the final stop bit completes: done=1 for exactly one cycle, packets_sent increments, tx stays 1.
  - busy drops in that same cycle unless a pending packet is launched.
- send while busy:
  - Sets pending=1. Multiple requests collapse into one.
  - At packet end with pending=1: pending clears, a fresh snapshot is captured in the done cycle, busy stays high, and the next start bit begins on the following cycle.
  - done still pulses in that cycle.
- Input stability: inputs changing mid-packet never alter bytes already in flight.
- Reset mid-packet: on the next edge tx=1, busy=0, pending=0, packets_sent=0. No partial-byte completion.
- Counters: the baud counter is sized ceil(log2(CLKS_PER_BIT)). The byte index is 4 bits and covers 0..12.

Test Plan:
- Idle after reset, send=0 for 1000 cycles -> tx=1, busy=0, done never asserted, packets_sent=0.
- Single packet (CLKS_PER_BIT=4):
  - Stimulus: player_id=1, game_state=2, time_left=150, point_total=300, orders=4'b0101, player_state=3, team_name="ABC", direction=1, x=304, y=208; one-cycle send.
  - Decoded bytes must be A5 42 96 01 2C 53 41 42 43 41 30 D0 5F.
  - done pulses exactly 520 cycles after the first start-bit cycle; packets_sent=1.
- Input change mid-packet: change time_left to 0 at byte 5 -> B2 still 0x96 and checksum still 0x5F.
- Back-to-back requests: send pulsed three times during packet 1 -> exactly one extra packet, starting the cycle after done with no idle gap; packets_sent=2.
- Reset mid-packet: assert reset during B4 data bits -> tx=1, busy=0 next cycle. A new send afterward produces a full, correct packet beginning with 0xA5.
- Counter wrap: force packets_sent=16'hFFFF, complete one packet -> packets_sent=0.
